// File: rtl/tt_tbuf_oe_seq.sv
// ---------------------------------------------------------------------------
// tt_tbuf_oe_seq
//
// Sequences the output enable of a tristate driver that shares a net with a
// second driver. A request is granted only after a bus-turnaround dead time
// has elapsed with the other driver quiet. The enable is released through the
// same dead time. A collision with the other driver is flagged and forces a
// release.
//
// State machine: OFF -> GAP_ON -> ON -> GAP_OFF -> OFF, with a 4-bit dead-time
// down-counter shared by both gap states.
//
// oe is registered and follows the state one edge behind. It rises on the
// edge after the FSM enters ON and falls on the edge the FSM leaves ON. As a
// result, the pad sees DEAD_CYC+1 quiet cycles before it is driven, and
// DEAD_CYC quiet cycles after release before a new request is taken.
//
// Optional feature (macro TT_TBUF_SEQ_WDOG_EN):
//   Adds an on-time watchdog. After MAX_ON cycles with oe high, the block
//   forces a release and sets the sticky timeout flag. A new grant then waits
//   until drv_req has been seen low in OFF. Without the macro there is no
//   watchdog and timeout is tied low.
//
// Parameters:
//   DEAD_CYC     - turnaround dead time in clk cycles (1..15)
//   MAX_ON       - watchdog drive limit in clk cycles (1..255)
//
// Ports:
//   clk          - clock, all flops on the rising edge
//   rst_n        - synchronous active-low reset
//   drv_req      - local request to drive the shared net
//   ext_oe       - enable of the other driver on the same net
//   conflict_clr - clears the sticky conflict and timeout flags
//   oe           - registered positive-polarity tristate enable
//   drv_ack      - copy of oe
//   conflict     - sticky driver-collision flag
//   timeout      - sticky watchdog-release flag
// ---------------------------------------------------------------------------
module tt_tbuf_oe_seq #(
  parameter int unsigned DEAD_CYC = 2,
  parameter int unsigned MAX_ON   = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic drv_req,
  input  logic ext_oe,
  input  logic conflict_clr,
  output logic oe,
  output logic drv_ack,
  output logic conflict,
  output logic timeout
);

  // Elaboration-time guard on the parameter ranges.
  if (DEAD_CYC < 1 || DEAD_CYC > 15 || MAX_ON < 1 || MAX_ON > 255) begin : g_bad_param
    $error("tt_tbuf_oe_seq: DEAD_CYC must be 1..15 and MAX_ON 1..255");
  end

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    GAP_ON  = 2'd1,
    ON      = 2'd2,
    GAP_OFF = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(DEAD_CYC - 1);

  state_t     state;
  logic [3:0] gap_cnt;

  logic wd_hit;    // watchdog limit reached while in ON
  logic wd_block;  // grant inhibited until drv_req is seen low in OFF
  logic start_ok;  // OFF may begin a new turnaround gap
  logic enter_on;  // GAP_ON completes this edge
  logic leave_on;  // ON is abandoned this edge
  logic conflict_set;

  assign start_ok     = drv_req && !ext_oe && !wd_block;
  assign enter_on     = (state == GAP_ON) && drv_req && !ext_oe && (gap_cnt == 4'd0);
  assign leave_on     = (state == ON) && (!drv_req || ext_oe || wd_hit);
  // A collision is the other driver enabled while this side owns the net.
  // This covers oe already high and the first ON cycle before oe rises.
  assign conflict_set = ext_oe && ((state == ON) || oe);

  // NOTE: every flop below is written with <= so all state updates see the
  // pre-edge values; blocking assignments here would create order-dependent
  // simulation and a mismatch against synthesis.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= OFF;
      gap_cnt  <= 4'd0;
      oe       <= 1'b0;
      drv_ack  <= 1'b0;
      conflict <= 1'b0;
    end else begin
      unique case (state)
        OFF: begin
          if (start_ok) begin
            state   <= GAP_ON;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP_ON: begin
          // An abort takes priority over a reload. Any activity by the other
          // driver restarts the dead time from the beginning.
          if (!drv_req) begin
            state <= OFF;
          end else if (ext_oe) begin
            gap_cnt <= GAP_LOAD;
          end else if (gap_cnt == 4'd0) begin
            state <= ON;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        ON: begin
          if (leave_on) begin
            state   <= GAP_OFF;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP_OFF: begin
          // After the gap, always return to OFF. A held request is then
          // taken as a fresh request one cycle later.
          if (gap_cnt == 4'd0) begin
            state <= OFF;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= OFF;
      endcase

      // oe is high only while ON is held. It drops on the same edge that
      // ON is left, so no input reaches oe combinationally.
      oe      <= (state == ON) && !leave_on;
      drv_ack <= (state == ON) && !leave_on;

      // On the same edge, a set beats a clear.
      if (conflict_set) begin
        conflict <= 1'b1;
      end else if (conflict_clr) begin
        conflict <= 1'b0;
      end
    end
  end

`ifdef TT_TBUF_SEQ_WDOG_EN
  localparam logic [7:0] ON_LIMIT = 8'(MAX_ON);

  logic [7:0] on_cnt;  // counts oe-high cycles of the current ON visit

  assign wd_hit = (state == ON) && (on_cnt == ON_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      on_cnt   <= 8'd0;
      wd_block <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (enter_on) begin
        on_cnt <= 8'd0;
      end else if ((state == ON) && !leave_on) begin
        on_cnt <= on_cnt + 8'd1;
      end

      if (wd_hit) begin
        wd_block <= 1'b1;
      end else if ((state == OFF) && !drv_req) begin
        wd_block <= 1'b0;
      end

      if (wd_hit) begin
        timeout <= 1'b1;
      end else if (conflict_clr) begin
        timeout <= 1'b0;
      end
    end
  end
`else
  assign wd_hit   = 1'b0;
  assign wd_block = 1'b0;
  assign timeout  = 1'b0;

  // enter_on only feeds the watchdog; keep it referenced in this build.
  logic unused_enter_on;
  assign unused_enter_on = enter_on;
`endif

endmodule

// File: doc/tt_tbuf_oe_seq.md
TT_TBUF_OE_SEQ -- requirements
Module: tt_tbuf_oe_seq

Interface
REQ-001 The block SHALL have parameter DEAD_CYC, default 2, legal range 1..15, giving the bus-turnaround dead time in clk cycles.
REQ-002 The block SHALL have parameter MAX_ON, default 255, legal range 1..255, giving the watchdog drive limit in clk cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have port drv_req, input, 1 bit: local request to drive the shared pad/bus.
REQ-006 The block SHALL have port ext_oe, input, 1 bit: the enable of the other driver on the same net.
REQ-007 The block SHALL have port conflict_clr, input, 1 bit: clears the sticky flags.
REQ-008 The block SHALL have port oe, output, 1 bit: positive-polarity tristate enable that feeds the polarity-handler stage's t input.
REQ-009 The block SHALL have port drv_ack, output, 1 bit: high exactly while oe is high.
REQ-010 The block SHALL have port conflict, output, 1 bit: sticky flag for a driver collision.
REQ-011 The block SHALL have port timeout, output, 1 bit: sticky flag for a watchdog release.

Function
REQ-012 The block SHALL implement four states, OFF, GAP_ON, ON and GAP_OFF, plus a 4-bit dead-time down-counter.
REQ-013 oe SHALL come directly from a flop, be high only in ON, and have no combinational path from any input.
REQ-014 OFF SHALL go to GAP_ON when drv_req=1 and ext_oe=0; on entry the counter SHALL load DEAD_CYC-1.
REQ-015 In GAP_ON, the counter SHALL decrement every cycle; ext_oe=1 SHALL reload it to DEAD_CYC-1.
REQ-016 GAP_ON SHALL go to ON when the counter is 0, ext_oe=0 and drv_req=1.
REQ-017 drv_req=0 in GAP_ON SHALL return the FSM to OFF next edge, with oe never asserted.
REQ-018 Latency: with ext_oe held low, oe SHALL rise on the (DEAD_CYC+1)th rising edge after the edge that samples drv_req=1 in OFF.
REQ-019 ON SHALL go to GAP_OFF when drv_req=0; on entry the counter SHALL load DEAD_CYC-1.
REQ-020 ext_oe=1 sampled in ON SHALL move the FSM to GAP_OFF and set conflict on the same edge.
REQ-021 GAP_OFF SHALL hold oe=0 for DEAD_CYC cycles, then go to OFF regardless of drv_req.
REQ-022 A drv_req held high through GAP_OFF SHALL be serviced from OFF on the following cycle as a new request.
REQ-023 conflict SHALL also set whenever oe=1 and ext_oe=1 are sampled on the same edge.
REQ-024 conflict_clr=1 SHALL clear conflict and timeout; a set condition on the same edge SHALL win over the clear.
REQ-025 drv_ack SHALL equal oe on every cycle.

Reset
REQ-026 rst_n=0 sampled on an edge SHALL force state OFF, counter 0, and oe, drv_ack, conflict and timeout all to 0.
REQ-027 Reset asserted during ON SHALL drop oe on that same edge with no GAP_OFF phase.
REQ-028 The first request after reset release SHALL see the full DEAD_CYC gap.

Configuration
REQ-029 Macro TT_TBUF_SEQ_WDOG_EN defined: an 8-bit counter SHALL clear on entry to ON and count the cycles spent in ON.
REQ-030 With the macro defined, reaching MAX_ON cycles in ON SHALL force GAP_OFF and set timeout.
REQ-031 With the macro defined, after a timeout drv_req SHALL be low for at least one cycle in OFF before a new request is accepted.
REQ-032 Macro not defined: there SHALL be no watchdog logic, timeout SHALL be tied to 0, and ON SHALL be left only via REQ-019, REQ-020 or reset.

Verification
REQ-033 Bench scenario, normal handshake: DEAD_CYC=2, ext_oe=0, drv_req rises and is sampled at edge 0 -> oe and drv_ack rise at edge 3; drv_req falls at edge 10 -> oe falls at edge 11, FSM in OFF at edge 13.
REQ-034 Bench scenario, gap restart: DEAD_CYC=3, ext_oe pulses for 1 cycle midway through GAP_ON -> counter reloads, oe rises 3 cycles after ext_oe falls, conflict stays 0.
REQ-035 Bench scenario, collision: in ON, ext_oe=1 for 1 cycle -> oe=0 next edge, conflict=1 and stays 1; conflict_clr pulse -> conflict=0.
REQ-036 Bench scenario, abort and reset: drv_req drops in GAP_ON -> oe never asserts, FSM returns to OFF; rst_n=0 in ON -> all outputs 0 on that edge.
REQ-037 Bench scenario, watchdog on: TT_TBUF_SEQ_WDOG_EN defined, MAX_ON=8, drv_req held high -> oe is high for exactly 8 cycles and timeout=1; no re-grant until drv_req toggles low.
REQ-038 Bench scenario, watchdog off: macro not defined, drv_req held high for 1000 cycles -> oe stays high and timeout stays 0.
